// File: rtl/y86_pkg.sv
// Y86-64 encodings shared by the pipeline stages: icodes, status codes and
// instruction-format helpers.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE    = 4'hF;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   function automatic logic need_regids(input logic [3:0] icode);
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
         I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
         default:                need_regids = 1'b0;
      endcase
   endfunction

   function automatic logic need_valc(input logic [3:0] icode);
      case (icode)
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valc = 1'b1;
         default:                                     need_valc = 1'b0;
      endcase
   endfunction

   function automatic logic instr_valid(input logic [3:0] icode, input logic [3:0] ifun);
      case (icode)
         I_RRMOVQ, I_JXX: instr_valid = (ifun <= 4'd6);
         I_OPQ:           instr_valid = (ifun <= 4'd3);
         I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
         I_CALL, I_RET, I_PUSHQ, I_POPQ: instr_valid = (ifun == 4'd0);
         default:         instr_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetched-instruction bundle handed from the fetch stage to the decode register.
interface fetch_stage_if;
   logic [2:0]  f_stat;
   logic [3:0]  f_icode;
   logic [3:0]  f_ifun;
   logic [3:0]  f_rA;
   logic [3:0]  f_rB;
   logic [63:0] f_valC;
   logic [63:0] f_valP;

   modport master (output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP);
   modport slave  (input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP);
endinterface

// File: rtl/instr_mem.sv
// Byte-addressed instruction memory: synchronous byte write, combinational
// 10-byte read window with a per-byte out-of-range flag.
module instr_mem #(
   parameter int IMEM_BYTES = 1024
) (
   input  logic            clk,
   input  logic            we,
   input  logic [63:0]     waddr,
   input  logic [7:0]      wdata,
   input  logic [63:0]     raddr,
   output logic [9:0][7:0] window,
   output logic [9:0]      oor
);
   localparam int         AW    = $clog2(IMEM_BYTES);
   localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);

   logic [7:0] mem [IMEM_BYTES];

   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < LIMIT))
         mem[waddr[AW-1:0]] <= wdata;
   end

   // 65-bit address sums so a window straddling 2^64 is flagged, not wrapped.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_window
         logic [64:0] byte_addr;
         assign byte_addr     = {1'b0, raddr} + 65'(gi);
         assign oor[gi]       = (byte_addr >= LIMIT);
         assign window[gi]    = oor[gi] ? 8'h00 : mem[byte_addr[AW-1:0]];
      end
   endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch: PC selection, instruction split/validation and the F
// (predicted PC) pipeline register.
module fetch_stage
   import y86_pkg::*;
#(
   parameter int          IMEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC   = 64'h0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          F_stall,
   input  logic [3:0]    M_icode,
   input  logic          M_Cnd,
   input  logic [63:0]   M_valA,
   input  logic [3:0]    W_icode,
   input  logic [63:0]   W_valM,
   input  logic          imem_we,
   input  logic [63:0]   imem_waddr,
   input  logic [7:0]    imem_wdata,
   fetch_stage_if.master fetch,
   output logic [63:0]   f_pc,
   output logic [63:0]   F_predPC
);
   logic [9:0][7:0] window;
   logic [9:0]      oor;
   logic [9:0]      len_mask;
   logic [3:0]      icode_raw;
   logic [3:0]      ifun_raw;
   logic            has_regids;
   logic            has_valc;
   logic            adr_err;
   logic [3:0]      instr_len;
   logic [63:0]     valc_raw;
   logic [63:0]     valp;
   logic [63:0]     pred_pc;
   stat_e           stat;

   always_comb begin
      f_pc = F_predPC;
      if (M_icode == I_JXX && !M_Cnd)
         f_pc = M_valA;
      else if (W_icode == I_RET)
         f_pc = W_valM;
   end

   instr_mem #(.IMEM_BYTES(IMEM_BYTES)) u_imem (
      .clk    (clk),
      .we     (imem_we),
      .waddr  (imem_waddr),
      .wdata  (imem_wdata),
      .raddr  (f_pc),
      .window (window),
      .oor    (oor)
   );

   assign icode_raw  = window[0][7:4];
   assign ifun_raw   = window[0][3:0];
   assign has_regids = need_regids(icode_raw);
   assign has_valc   = need_valc(icode_raw);
   // Packed slices keep the higher address in the upper byte: little-endian valC.
   assign valc_raw   = has_regids ? window[9:2] : window[8:1];
   assign instr_len  = 4'd1 + {3'b000, has_regids} + (has_valc ? 4'd8 : 4'd0);
   assign valp       = f_pc + 64'(instr_len);

   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_len_mask
         assign len_mask[gi] = (4'(gi) < instr_len);
      end
   endgenerate

   assign adr_err = |(oor & len_mask);

   always_comb begin
      fetch.f_icode = icode_raw;
      fetch.f_ifun  = ifun_raw;
      fetch.f_rA    = has_regids ? window[1][7:4] : RNONE;
      fetch.f_rB    = has_regids ? window[1][3:0] : RNONE;
      fetch.f_valC  = has_valc ? valc_raw : 64'h0;
      fetch.f_valP  = valp;
      stat          = STAT_AOK;
      if (adr_err) begin
         stat          = STAT_ADR;
         fetch.f_icode = I_NOP;
         fetch.f_ifun  = 4'h0;
         fetch.f_rA    = RNONE;
         fetch.f_rB    = RNONE;
         fetch.f_valC  = 64'h0;
      end else if (!instr_valid(icode_raw, ifun_raw)) begin
         stat = STAT_INS;
      end else if (icode_raw == I_HALT) begin
         stat = STAT_HLT;
      end
      fetch.f_stat = stat;
   end

   // Only a good jump/call redirects; faulting instructions fall through to valP.
   assign pred_pc = (stat == STAT_AOK && (icode_raw == I_JXX || icode_raw == I_CALL))
                    ? valc_raw : valp;

   always_ff @(posedge clk) begin
      if (reset)
         F_predPC <= RESET_PC;
      else if (!F_stall)
         F_predPC <= pred_pc;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the Y86-64 pipeline: holds the F pipeline register (predicted PC), selects the fetch PC, reads and splits the instruction from an internal byte-addressed instruction memory, and drives the `f_*` signals consumed by the decode pipeline register. It is the producer side of the decode register interface, fed back from the M and W stages for PC correction, and honours `F_stall` from pipeline control.

## Interface
- `IMEM_BYTES`, 1024: instruction memory size in bytes.
- `RESET_PC`, 64'h0: value loaded into `F_predPC` on reset.
- `clk` input 1: single clock, all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `F_stall` input 1: hold `F_predPC` when 1.
- `M_icode` input 4, `M_Cnd` input 1, `M_valA` input 64: mispredicted-jump correction.
- `W_icode` input 4, `W_valM` input 64: return-address correction.
- `imem_we` input 1, `imem_waddr` input 64, `imem_wdata` input 8: bench/loader byte write port.
- `f_stat` output 3, `f_icode` output 4, `f_ifun` output 4, `f_rA` output 4, `f_rB` output 4, `f_valC` output 64, `f_valP` output 64: fetched instruction to decode register.
- `f_pc` output 64: selected fetch PC (debug/trace).
- `F_predPC` output 64: F pipeline register.

## Operation
- Encodings: icode 0 HALT, 1 NOP, 2 RRMOVQ/CMOV, 3 IRMOVQ, 4 RMMOVQ, 5 MRMOVQ, 6 OPQ, 7 JXX, 8 CALL, 9 RET, A PUSHQ, B POPQ. Stat: AOK=1, HLT=2, ADR=3, INS=4. Register none = 4'hF.
- PC select, priority order: `M_icode==JXX && !M_Cnd` -> `M_valA`; else `W_icode==RET` -> `W_valM`; else `F_predPC`.
- Byte 0 at `f_pc`: icode = [7:4], ifun = [3:0].
- need_regids: icode in {2,3,4,5,6,A,B}; register byte at `f_pc+1`, rA = [7:4], rB = [3:0]; otherwise rA = rB = F.
- need_valC: icode in {3,4,5,7,8}; 8 bytes little-endian at `f_pc+1+need_regids`; otherwise valC = 0.
- valP = `f_pc + 1 + need_regids + 8*need_valC` (64-bit, wraps mod 2^64).
- Valid: icode ≤ B; ifun ≤ 6 for icode 2 and 7; ifun ≤ 3 for icode 6; ifun = 0 for all others.
- Address error: any byte of the instruction (length from valP−f_pc) at address ≥ `IMEM_BYTES`. Then icode = NOP, ifun = 0, rA = rB = F, valC = 0.
- f_stat: ADR if address error; else INS if invalid; else HLT if icode = HALT; else AOK.
- Predicted PC: valC for JXX and CALL, else valP. ADR/INS/HLT still predict valP.
- Memory writes: `imem_we` stores `imem_wdata` at `imem_waddr` if in range, ignored otherwise. Reset does not clear memory.

## Timing
- All `f_*` and `f_pc` outputs are combinational from `F_predPC`, M/W inputs and memory (zero latency). The decode register captures them at the next edge.
- `F_predPC` updates at posedge to predicted PC when `!F_stall && !reset`. It holds when `F_stall=1`.
- Reset: `F_predPC <= RESET_PC` at the edge where `reset=1`, regardless of `F_stall`. Outputs then reflect fetch at `RESET_PC`.
- Memory write is visible to fetch in the cycle after the write edge. A same-cycle read returns the old byte.

## Structure
- Shared package `y86_pkg`: icode constants, stat codes, `RNONE`, and need_regids/need_valC/valid helper functions, reused by the decode and execute stages.
- Sub-module `instr_mem`: byte array with sync write and combinational 10-byte read window starting at an address, plus per-byte out-of-range flags.

## Test plan
- Reset with `RESET_PC=0`; memory bytes `30 F0 00 01 00 00 00 00 00 00` at 0 -> f_icode 3, rA F, rB 0, valC 0x100, valP 10, stat AOK; `F_predPC`=10 after one edge.
- `70 20 00 00 00 00 00 00 00` (jmp 0x20) at 0 -> predPC 0x20. Later `M_icode=7, M_Cnd=0, M_valA=0x9` -> f_pc 0x9. Apply together with `W_icode=9, W_valM=0x40` -> f_pc still 0x9.
- `W_icode=9, W_valM=0x40` alone -> f_pc 0x40. `F_stall=1` for 3 cycles -> `F_predPC` unchanged.
- irmovq placed at `IMEM_BYTES-4` -> stat ADR, icode 1, rA/rB F, valC 0.
- Byte `C0` -> stat INS. Byte `61` -> AOK. Byte `64` -> INS. Byte `00` -> HLT, valP = pc+1.
- Assert `reset` while `F_stall=1` mid-program -> `F_predPC=RESET_PC` next edge.
